// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA frame-path loader blocks.
//   - copier_state_e : FSM encodings for the ROM-to-RAM copier
//   - DEFAULT_DATA_W / DEFAULT_ADDR_W : default memory geometry
//   - rom_image_word : built-in ROM image, one word per address
package vga_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_COPY  = 2'd2,
    S_DONE  = 2'd3
  } copier_state_e;

  // Built-in image: word(a) = (a+1) ^ ((a>>2) << 16). Low addresses hold
  // 1,2,3,4,... so small copies are easy to recognise on the read port.
  function automatic logic [63:0] rom_image_word(input int unsigned addr);
    return 64'(addr + 32'd1) ^ (64'(addr >> 2) << 16);
  endfunction

endpackage

// File: rtl/rom2ram_copier_sync_rom.sv
// sync_rom: single-port ROM with a registered output (1-cycle read latency).
// Parameters:
//   ADDR_W   address width, DEPTH = 2**ADDR_W words
//   DATA_W   word width
//   ROM_INIT image name; an empty name gives a blank (all-zero) ROM, any
//            other name selects the built-in image from vga_pkg, which is
//            elaborated as constants so no file is read at build time.
// Ports:
//   clk   in  1       rising-edge clock
//   addr  in  ADDR_W  read address
//   data  out DATA_W  ROM[addr] registered on the next edge
module sync_rom
  import vga_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter     ROM_INIT = "rom_init.hex"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rom_mem [DEPTH];
  logic [DATA_W-1:0] data_q, data_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_image
      if (ROM_INIT == "") begin : g_blank
        assign rom_mem[gi] = '0;
      end else begin : g_word
        assign rom_mem[gi] = DATA_W'(rom_image_word(gi));
      end
    end
  endgenerate

  always_comb begin
    data_d = rom_mem[addr];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/rom2ram_copier.sv
// rom2ram_copier: copies LEN words from an internal ROM (src_base..) into an
// internal RAM (dst_base..), one word per clock after a 1-cycle ROM prime,
// then pulses done. A registered RAM read port runs every cycle, including
// during a copy (read-first on a same-address write).
// Optional feature macro: CHECKSUM_EN adds the checksum port and adder.
// Ports:
//   clk       in  1         rising-edge clock
//   reset     in  1         synchronous, active-high
//   start     in  1         copy request, honoured only when idle
//   src_base  in  ADDR_W    first ROM address (sampled with start)
//   dst_base  in  ADDR_W    first RAM address (sampled with start)
//   len       in  ADDR_W+1  word count 0..DEPTH (sampled with start)
//   busy      out 1         high while priming/copying
//   done      out 1         1-cycle completion pulse
//   rd_addr   in  ADDR_W    RAM read address
//   rd_data   out DATA_W    RAM[rd_addr], 1-cycle latency
//   checksum  out DATA_W    (CHECKSUM_EN) sum of words copied by last start
module rom2ram_copier
  import vga_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter     ROM_INIT = "rom_init.hex"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  copier_state_e     state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ram_we;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] ram_mem [DEPTH];

  // src_q is always the ROM address; it runs one word ahead of dst_q so the
  // ROM output lines up with the RAM write address in COPY.
  sync_rom #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_INIT(ROM_INIT)
  ) u_rom (
    .clk (clk),
    .addr(src_q),
    .data(rom_q)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    ram_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          cnt_d   = len;
          state_d = (len == '0) ? S_DONE : S_PRIME;
        end
      end
      S_PRIME: begin
        src_d   = src_q + ADDR_W'(1);
        state_d = S_COPY;
      end
      S_COPY: begin
        // Reset on this edge aborts the copy before the write lands.
        ram_we = !reset;
        src_d  = src_q + ADDR_W'(1);
        dst_d  = dst_q + ADDR_W'(1);
        cnt_d  = cnt_q - (ADDR_W + 1)'(1);
        if (cnt_q == (ADDR_W + 1)'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Simple dual-port RAM: contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[dst_q] <= rom_q;
    end
  end

  // Read-first: on a same-address write this edge returns the old word.
  always_comb begin
    rd_data_d = ram_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign busy    = (state_q == S_PRIME) || (state_q == S_COPY);
  assign done    = (state_q == S_DONE);
  assign rd_data = rd_data_q;

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == S_IDLE && start) begin
      checksum_d = '0;
    end else if (ram_we) begin
      checksum_d = checksum_q + rom_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rom2ram_copier.sv
// Self-checking bench for rom2ram_copier. A timing/array model predicts busy,
// done, rd_data (and checksum) after every edge; a compare process checks
// them each cycle, and directed copies pin latencies and RAM words to
// hand-computed literals.
module tb_rom2ram_copier;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_base = '0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic [ADDR_W:0]   len = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  always #5 clk = ~clk;

  rom2ram_copier #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ROM_INIT("rom_init.hex")
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .src_base(src_base),
    .dst_base(dst_base),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`ifdef CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [DATA_W-1:0] rom_word(input int a);
    int w;
    w = a % DEPTH;
    return DATA_W'(w + 1) ^ (DATA_W'(w / 4) << 16);
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] ram_m [DEPTH];
  bit                known_m [DEPTH];
  int                edge_n = 0;
  bit                active = 0;
  int                t0 = 0, m_len = 0, m_src = 0, m_dst = 0, done_edge = 0;
  logic              exp_busy = 1'b0;
  logic              exp_done = 1'b0;
  logic [DATA_W-1:0] exp_rd = '0;
  bit                exp_rd_known = 0;
  logic [DATA_W-1:0] exp_sum = '0;

  // Copy accepted at edge t0 writes word k at edge t0+2+k; busy covers the
  // cycles after edges t0..t0+len; done follows edge t0+len+1 (t0 if len=0).
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        active       = 0;
        exp_busy     = 1'b0;
        exp_done     = 1'b0;
        exp_rd       = '0;
        exp_rd_known = 1;
        exp_sum      = '0;
      end else begin
        exp_rd_known = known_m[rd_addr];
        exp_rd       = ram_m[rd_addr];
        if (active) begin
          int k;
          k = edge_n - t0 - 2;
          if (k >= 0 && k < m_len) begin
            int a;
            a = (m_dst + k) % DEPTH;
            ram_m[a]   = rom_word(m_src + k);
            known_m[a] = 1;
            exp_sum    = exp_sum + rom_word(m_src + k);
          end
        end
        if (start && (!active || edge_n >= done_edge + 2)) begin
          active    = 1;
          t0        = edge_n;
          m_len     = int'(len);
          m_src     = int'(src_base);
          m_dst     = int'(dst_base);
          done_edge = (m_len == 0) ? t0 : t0 + m_len + 1;
          exp_sum   = '0;
        end
        exp_busy = active && m_len > 0 && edge_n >= t0 && edge_n <= t0 + m_len;
        exp_done = active && edge_n == done_edge;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (edge_n > 0) begin
        checks++;
        if (busy !== exp_busy) begin
          failures++;
          $display("FAIL cyc_busy edge=%0d got=%0b want=%0b", edge_n, busy, exp_busy);
        end
        checks++;
        if (done !== exp_done) begin
          failures++;
          $display("FAIL cyc_done edge=%0d got=%0b want=%0b", edge_n, done, exp_done);
        end
        if (exp_rd_known) begin
          checks++;
          if (rd_data !== exp_rd) begin
            failures++;
            $display("FAIL cyc_rd edge=%0d addr=%0h got=%0h want=%0h",
                     edge_n, rd_addr, rd_data, exp_rd);
          end
        end
`ifdef CHECKSUM_EN
        checks++;
        if (checksum !== exp_sum) begin
          failures++;
          $display("FAIL cyc_sum edge=%0d got=%0h want=%0h", edge_n, checksum, exp_sum);
        end
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  // Entered and left at a negedge. n counts negedges after the accept edge.
  task automatic run_copy(input int src, input int dst, input int l,
                          input int repulse_at, input int abort_at, input int rd_a,
                          output int lat, output int ndone, output int nbusy,
                          output logic [DATA_W-1:0] rd4, output logic [DATA_W-1:0] rd5,
                          output logic [DATA_W-1:0] sum_at_done);
    rd_addr  = ADDR_W'(rd_a);
    src_base = ADDR_W'(src);
    dst_base = ADDR_W'(dst);
    len      = (ADDR_W + 1)'(l);
    start    = 1'b1;
    lat = 0; ndone = 0; nbusy = 0; rd4 = '0; rd5 = '0; sum_at_done = '0;
    @(posedge clk);
    for (int n = 1; n <= l + 8; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = n;
`ifdef CHECKSUM_EN
          sum_at_done = checksum;
`endif
        end
      end
      if (busy) nbusy++;
      if (n == 4) rd4 = rd_data;
      if (n == 5) rd5 = rd_data;
      if (n == 1) start = 1'b0;
      if (n == repulse_at) begin
        start    = 1'b1;
        len      = (ADDR_W + 1)'(3);
        dst_base = 8'h90;
      end
      if (n == repulse_at + 1) start = 1'b0;
      if (n == abort_at) reset = 1'b1;
      if (n == abort_at + 1) reset = 1'b0;
    end
    $display("copy src=%0h dst=%0h len=%0d lat=%0d dones=%0d busy_cycles=%0d",
             src, dst, l, lat, ndone, nbusy);
  endtask

  task automatic read_word(input int a, output logic [DATA_W-1:0] v);
    rd_addr = ADDR_W'(a);
    @(negedge clk);
    v = rd_data;
    $display("read addr=%0h data=%0h", a, v);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int lat, nd, nb;
    logic [DATA_W-1:0] r4, r5, sm, v;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    reset = 1'b0;

    // 1: basic 8-word copy
    run_copy(0, 0, 8, 0, 0, 0, lat, nd, nb, r4, r5, sm);
    check("t1_latency", lat, 10);
    check("t1_dones", nd, 1);
    check("t1_busy_cycles", nb, 9);
    for (int a = 0; a < 8; a++) begin
      read_word(a, v);
      check("t1_ram", v, rom_word(a));
    end
    read_word(0, v); check("t1_ram0_lit", v, 32'h0000_0001);
    read_word(7, v); check("t1_ram7_lit", v, 32'h0001_0008);

    // full-memory copy (len == DEPTH), fills RAM with ROM[a+0x40]
    run_copy(8'h40, 0, DEPTH, 0, 0, 0, lat, nd, nb, r4, r5, sm);
    check("full_latency", lat, DEPTH + 2);
    check("full_busy_cycles", nb, DEPTH + 1);
    read_word(8'hFF, v); check("full_ramFF_lit", v, 32'h000F_0040);

    // 2: len == 0
    run_copy(0, 0, 0, 0, 0, 0, lat, nd, nb, r4, r5, sm);
    check("t2_latency", lat, 1);
    check("t2_busy_cycles", nb, 0);
    check("t2_dones", nd, 1);
    read_word(0, v); check("t2_ram0_kept", v, 32'h0010_0041);

    // 3: destination wrap
    run_copy(8'h10, 8'hFE, 4, 0, 0, 0, lat, nd, nb, r4, r5, sm);
    check("t3_latency", lat, 6);
    read_word(8'hFE, v); check("t3_ramFE", v, 32'h0004_0011);
    read_word(8'h01, v); check("t3_ram01", v, 32'h0004_0014);
    read_word(8'h02, v); check("t3_ram02_kept", v, 32'h0010_0043);

    // 4: second start mid-copy is ignored
    run_copy(8'h20, 8'h80, 8, 4, 0, 0, lat, nd, nb, r4, r5, sm);
    check("t4_latency", lat, 10);
    check("t4_dones", nd, 1);
    check("t4_busy_cycles", nb, 9);
    read_word(8'h87, v); check("t4_ram87", v, 32'h0009_0028);
    read_word(8'h90, v); check("t4_ram90_kept", v, 32'h0034_00D1);

    // 5: reset sampled at edge T5 of an 8-word copy
    run_copy(0, 0, 8, 0, 5, 0, lat, nd, nb, r4, r5, sm);
    check("t5_dones", nd, 0);
    check("t5_busy_cycles", nb, 5);
    check("t5_busy_after", {31'b0, busy}, 32'd0);
    read_word(2, v); check("t5_ram2_new", v, 32'h0000_0003);
    read_word(3, v); check("t5_ram3_old", v, 32'h0010_0044);
    read_word(7, v); check("t5_ram7_old", v, 32'h0011_0048);

    // 6: read-first on the write cycle, checksum
    run_copy(0, 8'h20, 4, 0, 0, 8'h21, lat, nd, nb, r4, r5, sm);
    check("t6_latency", lat, 6);
    check("t6_rd_old", r4, 32'h0018_0062);
    check("t6_rd_new", r5, 32'h0000_0002);
`ifdef CHECKSUM_EN
    check("t6_checksum", sm, 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
